// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: pcsrc encodings,
// FSM state type and the NOP word used for bubbles.
package if_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // FETCH: request outstanding; HOLD: word parked, no request;
  // DROP: request outstanding but its data belongs to a squashed path.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DROP  = 2'b10
  } if_state_e;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory
// (slave). One request outstanding; ack completes it with rdata valid.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A decode stall freezes every field; otherwise it
// either captures a fetched word or collapses to a bubble (NOP, valid=0).
// On a bubble the pc4 field keeps its old value.
module if_id_reg
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        valid
);

  // Hold on stall, else load a live word or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst  <= NOP_INST;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (!stall) begin
      if (load && !flush) begin
        inst  <= inst_in;
        pc4   <= pc4_in;
        valid <= 1'b1;
      end else begin
        inst  <= NOP_INST;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM (FETCH/HOLD/DROP) and the IF/ID
// register. Optional macro IF_STALL_CNT_EN adds a stall_cnt output counting
// cycles spent stalled by decode or draining a squashed request.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        imem,
  input  logic [1:0]        pcsrc,
  input  logic [31:0]       redirect_pc,
  input  logic              id_stall,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc4,
  output logic              if_valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic [31:0] hold_buf_q;
  logic        req_q;

  logic        ack;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  logic        idr_load;
  logic [31:0] idr_inst;
  logic [31:0] idr_pc4;

  // Low address bits of the target are dropped by word alignment.
  logic        unused_lsbs;
  assign unused_lsbs = ^redirect_pc[1:0];

  // An ack only counts while we are actually requesting; this also keeps a
  // stale ack from a pre-reset request from being consumed after release.
  assign ack      = imem.imem_ack & req_q;
  assign redir    = (pcsrc != PCSRC_SEQ) & ~id_stall;
  assign target   = word_align(redirect_pc);
  assign pc_plus4 = pc_q + 32'd4;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  // Pick what the IF/ID register would capture this cycle if not stalled.
  always_comb begin
    idr_load = 1'b0;
    idr_inst = imem.imem_rdata;
    idr_pc4  = pc_plus4;
    case (state_q)
      ST_FETCH: idr_load = ack;
      ST_HOLD: begin
        // PC already advanced past the parked word, so pc is its pc+4.
        idr_load = 1'b1;
        idr_inst = hold_buf_q;
        idr_pc4  = pc_q;
      end
      default: idr_load = 1'b0;
    endcase
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (id_stall),
    .flush   (redir),
    .load    (idr_load),
    .inst_in (idr_inst),
    .pc4_in  (idr_pc4),
    .inst    (if_inst),
    .pc4     (if_pc4),
    .valid   (if_valid)
  );

  // Fetch FSM with PC, pending-redirect and hold-buffer registers; imem_req
  // is registered and low only while a word is parked in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      hold_buf_q <= NOP_INST;
      req_q      <= 1'b0;
    end else begin
      req_q <= 1'b1;
      case (state_q)
        ST_FETCH: begin
          if (redir) begin
            if (ack) begin
              pc_q <= target;
            end else begin
              // Request already issued at the old pc: let it drain.
              pend_pc_q <= target;
              state_q   <= ST_DROP;
            end
          end else if (ack) begin
            pc_q <= pc_plus4;
            if (id_stall) begin
              hold_buf_q <= imem.imem_rdata;
              state_q    <= ST_HOLD;
              req_q      <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (redir) begin
            pc_q       <= target;
            hold_buf_q <= NOP_INST;
            state_q    <= ST_FETCH;
          end else if (!id_stall) begin
            state_q <= ST_FETCH;
          end else begin
            req_q <= 1'b0;
          end
        end
        ST_DROP: begin
          // A newer redirect replaces the pending one; last target wins.
          if (redir) pend_pc_q <= target;
          if (ack) begin
            pc_q    <= redir ? target : pend_pc_q;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

`ifdef IF_STALL_CNT_EN
  // Count cycles lost to decode stalls or draining a squashed request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt <= 32'h0;
    else if (id_stall || state_q == ST_DROP) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a behavioural model of the fetch rules.
`timescale 1ns/1ps
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] rpc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] inst, pc4, w_inst, w_pc4;
  logic        valid, w_valid;
`ifdef IF_STALL_CNT_EN
  logic [31:0] cnt, w_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  if_stage_if bus ();
  if_stage_if bus2 ();

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem(bus), .pcsrc(pcsrc), .redirect_pc(rpc),
    .id_stall(stall), .if_inst(inst), .if_pc4(pc4), .if_valid(valid)
`ifdef IF_STALL_CNT_EN
    , .stall_cnt(cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem(bus2), .pcsrc(pcsrc), .redirect_pc(rpc),
    .id_stall(stall), .if_inst(w_inst), .if_pc4(w_pc4), .if_valid(w_valid)
`ifdef IF_STALL_CNT_EN
    , .stall_cnt(w_cnt)
`endif
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_pend, m_inst, m_pc4, m_cnt;
  logic        m_valid;
  bit          m_drop, m_started;
  logic [31:0] m_buf[$];   // parked word (at most one)

  function automatic bit m_req();
    return m_started && (m_buf.size() == 0);
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_drop = 0; m_started = 0; m_buf.delete();
  endfunction

  function automatic void model_clk(input logic a, input logic [31:0] rd,
                                    input logic [1:0] ps, input logic [31:0] rp,
                                    input logic st);
    bit ack, redir, holding;
    logic [31:0] tgt;
    ack     = a && m_req();
    redir   = (ps != 2'b00) && !st;
    holding = (m_buf.size() != 0);
    tgt     = rp & 32'hFFFF_FFFC;
    if (st || m_drop) m_cnt = m_cnt + 1;
    // What decode sees next cycle.
    if (!st) begin
      if (!redir && holding) begin
        m_inst = m_buf[0]; m_pc4 = m_pc; m_valid = 1'b1;
      end else if (!redir && !m_drop && ack) begin
        m_inst = rd; m_pc4 = m_pc + 4; m_valid = 1'b1;
      end else begin
        m_inst = 32'h0; m_valid = 1'b0;
      end
    end
    // Where fetching goes next.
    if (holding) begin
      if (redir) m_pc = tgt;
      if (!st) m_buf.delete();
    end else if (m_drop) begin
      if (redir) m_pend = tgt;
      if (ack) begin m_drop = 0; m_pc = m_pend; end
    end else if (redir) begin
      if (ack) m_pc = tgt;
      else begin m_pend = tgt; m_drop = 1; end
    end else if (ack) begin
      if (st) m_buf.push_back(rd);
      m_pc = m_pc + 4;
    end
    m_started = 1;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic cyc(input logic a, input logic [31:0] rd, input logic [1:0] ps,
                     input logic [31:0] rp, input logic st);
    bus.imem_ack = a; bus.imem_rdata = rd; pcsrc = ps; rpc = rp; stall = st;
    @(posedge clk);
    model_clk(a, rd, ps, rp, st);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = 32'h0;
    pcsrc = 2'b00; rpc = 32'h0; stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = 32'h0;
    @(negedge clk);
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    n_chk++; if ({inst, pc4, valid} !== 65'h0) begin n_fail++; $display("FAIL reset_ifid: got %h/%h/%b want 0", inst, pc4, valid); end
    n_chk++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc_param: got %h want fffffffc", bus2.imem_addr); end
`ifdef IF_STALL_CNT_EN
    n_chk++; if (cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", cnt); end
`endif
  endtask

  task automatic test_seq();
    logic [31:0] w[4];
    apply_reset();
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_req_release: got %b want 0", bus.imem_req); end
    cyc(1'b1, 32'hBAD0_0000, 2'b00, 32'h0, 1'b0);   // stale ack, no request yet
    n_chk++; if (bus.imem_req !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL seq_first_req: got req=%b valid=%b want 1/0", bus.imem_req, valid); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, bus.imem_addr, 4 * i); end
      w[i] = $urandom;
      cyc(1'b1, w[i], 2'b00, 32'h0, 1'b0);
      n_chk++; if (inst !== w[i] || valid !== 1'b1 || pc4 !== 32'(4 * i + 4)) begin
        n_fail++; $display("FAIL seq_ifid%0d: got %h/%h/%b want %h/%h/1", i, inst, pc4, valid, w[i], 4 * i + 4); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] i0, i1;
    i0 = $urandom; i1 = $urandom;
    apply_reset();
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    cyc(1'b1, i0, 2'b00, 32'h0, 1'b0);
    cyc(1'b1, i1, 2'b00, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (inst !== i0 || pc4 !== 32'h4 || valid !== 1'b1) begin n_fail++; $display("FAIL stall_frozen%0d: got %h/%h/%b want %h/4/1", k, inst, pc4, valid, i0); end
      n_chk++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_hold%0d: got req=%b addr=%h want 0/8", k, bus.imem_req, bus.imem_addr); end
      if (k < 2) cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b1);
    end
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    n_chk++; if (inst !== i1 || pc4 !== 32'h8 || valid !== 1'b1) begin n_fail++; $display("FAIL stall_deliver: got %h/%h/%b want %h/8/1", inst, pc4, valid, i1); end
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_resume: got req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_drop();
    logic [31:0] i5;
    i5 = $urandom;
    apply_reset();
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 2'b10, 32'h0000_0403, 1'b0);
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL drop_addr_stable: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 2'b00, 32'h0, 1'b0);
    n_chk++; if (bus.imem_addr !== 32'h400 || valid !== 1'b0 || inst !== 32'h0) begin n_fail++; $display("FAIL drop_discard: got addr=%h inst=%h valid=%b want 400/0/0", bus.imem_addr, inst, valid); end
    cyc(1'b1, i5, 2'b00, 32'h0, 1'b0);
    n_chk++; if (inst !== i5 || pc4 !== 32'h404 || valid !== 1'b1) begin n_fail++; $display("FAIL drop_target: got %h/%h/%b want %h/404/1", inst, pc4, valid, i5); end
  endtask

  task automatic test_redirect_ack();
    logic [31:0] i7;
    i7 = $urandom;
    apply_reset();
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    cyc(1'b1, 32'h1111_1111, 2'b00, 32'h0, 1'b0);
    cyc(1'b1, 32'hBADB_AD00, 2'b01, 32'h0000_1002, 1'b0);
    n_chk++; if (valid !== 1'b0 || inst !== 32'h0 || bus.imem_addr !== 32'h1000) begin n_fail++; $display("FAIL redir_ack: got valid=%b inst=%h addr=%h want 0/0/1000", valid, inst, bus.imem_addr); end
    cyc(1'b1, i7, 2'b00, 32'h0, 1'b0);
    n_chk++; if (inst !== i7 || pc4 !== 32'h1004 || valid !== 1'b1) begin n_fail++; $display("FAIL redir_next: got %h/%h/%b want %h/1004/1", inst, pc4, valid, i7); end
  endtask

  task automatic test_wrap();
    logic [31:0] w0;
    w0 = $urandom;
    apply_reset();
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    n_chk++; if (bus2.imem_addr !== 32'hFFFF_FFFC || bus2.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_first: got addr=%h req=%b want fffffffc/1", bus2.imem_addr, bus2.imem_req); end
    bus2.imem_ack = 1'b1; bus2.imem_rdata = w0;
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    bus2.imem_ack = 1'b0;
    n_chk++; if (bus2.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", bus2.imem_addr); end
    n_chk++; if (w_inst !== w0 || w_pc4 !== 32'h0 || w_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pc4: got %h/%h/%b want %h/0/1", w_inst, w_pc4, w_valid, w0); end
  endtask

  task automatic test_reset_drop();
    logic [31:0] i9;
    i9 = $urandom;
    apply_reset();
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    cyc(1'b1, 32'h2222_2222, 2'b00, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 2'b10, 32'h0000_0800, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);            // sitting in DROP
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({inst, pc4, valid} !== 65'h0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rstdrop_async: got %h/%h/%b req=%b addr=%h want zeros", inst, pc4, valid, bus.imem_req, bus.imem_addr); end
`ifdef IF_STALL_CNT_EN
    n_chk++; if (cnt !== 32'h0) begin n_fail++; $display("FAIL rstdrop_cnt: got %h want 0", cnt); end
`endif
    @(posedge clk); @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    cyc(1'b1, 32'hBAD0_0BAD, 2'b00, 32'h0, 1'b0);    // stale ack must be ignored
    n_chk++; if (bus.imem_addr !== 32'h0 || valid !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rstdrop_restart: got addr=%h valid=%b req=%b want 0/0/1", bus.imem_addr, valid, bus.imem_req); end
    cyc(1'b1, i9, 2'b00, 32'h0, 1'b0);
    n_chk++; if (inst !== i9 || pc4 !== 32'h4 || valid !== 1'b1) begin n_fail++; $display("FAIL rstdrop_fetch: got %h/%h/%b want %h/4/1", inst, pc4, valid, i9); end
  endtask

  task automatic test_random();
    logic a, st;
    logic [1:0] ps;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      a  = bus.imem_req && ($urandom_range(0, 99) < 55);
      st = ($urandom_range(0, 99) < 25);
      ps = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc(a, $urandom, ps, $urandom, st);
      n_chk++; if (bus.imem_req !== m_req()) begin n_fail++; $display("FAIL rnd_req @%0d: got %b want %b", i, bus.imem_req, m_req()); end
      n_chk++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr @%0d: got %h want %h", i, bus.imem_addr, m_pc); end
      n_chk++; if (inst !== m_inst || valid !== m_valid) begin n_fail++; $display("FAIL rnd_inst @%0d: got %h/%b want %h/%b", i, inst, valid, m_inst, m_valid); end
      n_chk++; if (pc4 !== m_pc4) begin n_fail++; $display("FAIL rnd_pc4 @%0d: got %h want %h", i, pc4, m_pc4); end
`ifdef IF_STALL_CNT_EN
      n_chk++; if (cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt @%0d: got %h want %h", i, cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  word-aligned fetch address.
REQ-006 imem_ack  in  1  read data valid this cycle; completes the outstanding request.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 pcsrc  in  2  from decode control: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-009 redirect_pc  in  32  target address, sampled when pcsrc != 00.
REQ-010 id_stall  in  1  decode cannot accept a new instruction; hold IF/ID.
REQ-011 if_inst  out  32  IF/ID instruction register, feeds the control decoder.
REQ-012 if_pc4  out  32  IF/ID register holding fetch address + 4.
REQ-013 if_valid  out  1  if_inst holds a live instruction; 0 = bubble (if_inst = 0, a NOP).

Function
REQ-014 FSM states: FETCH (imem_req=1), HOLD (word buffered, imem_req=0), DROP (imem_req=1, stale request draining).
REQ-015 FETCH, ack, id_stall=0: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH.
REQ-016 FETCH, ack, id_stall=1: rdata into hold buffer; pc <= pc+4; go HOLD.
REQ-017 HOLD, id_stall=0: IF/ID <= hold buffer, valid=1; go FETCH next cycle.
REQ-018 id_stall=1: if_inst, if_pc4 and if_valid keep their values, with no exceptions.
REQ-019 imem_addr = pc; imem_addr stays stable while imem_req=1 and no ack.
REQ-020 Redirect (pcsrc != 00, id_stall=0): if_valid <= 0 and if_inst <= 0; hold buffer discarded; target = {redirect_pc[31:2], 2'b00}.
REQ-021 Redirect in FETCH with ack in the same cycle: rdata discarded; pc <= target; stay FETCH.
REQ-022 Redirect in FETCH with no ack: target into pend_pc; go DROP.
REQ-023 DROP, ack: data discarded; pc <= pend_pc; go FETCH.
REQ-024 Redirect in HOLD: pc <= target; go FETCH.
REQ-025 Redirect while id_stall=1: ignored; decode re-presents it after the stall.
REQ-026 Second redirect during DROP: pend_pc overwritten; the last target wins.
REQ-027 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-028 Fetch latency: ack in cycle N gives if_valid=1 in cycle N+1.

Reset
REQ-029 While rst_n=0: state=FETCH, pc=RESET_PC, if_inst=0, if_pc4=0, if_valid=0, hold buffer=0, pend_pc=0.
REQ-030 imem_req is 0 while rst_n=0 and goes to 1 on the first clock edge after release.
REQ-031 Reset mid-DROP or mid-HOLD: all state is discarded; no stale ack is consumed after release.

Configuration
REQ-032 Macro IF_STALL_CNT_EN defined: adds output stall_cnt [31:0]; it resets to 0, increments (wrapping) each cycle id_stall=1 or state=DROP, and otherwise holds.
REQ-033 Macro IF_STALL_CNT_EN undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-034 Shared package if_pkg holds: pcsrc encodings (PCSRC_SEQ/BR/J/JR), FSM state type, NOP_INST=32'h0.
REQ-035 One sub-module, if_id_reg: the IF/ID register with stall hold and flush-to-bubble; the FSM and PC stay in if_stage.

Verification
REQ-036 Reset release, ack every cycle -> imem_addr 0,4,8,C; if_inst follows rdata one cycle later; if_valid=1 from cycle 2.
REQ-037 id_stall=1 for 3 cycles with an ack in the first -> if_inst frozen; state HOLD; imem_req=0; word delivered on the cycle after id_stall falls.
REQ-038 pcsrc=10, redirect_pc=32'h0000_0403, no ack, ack 2 cycles later -> DROP; that data discarded; next imem_addr=32'h0000_0400.
REQ-039 pcsrc=01 with a simultaneous ack -> if_valid=0 next cycle; imem_addr=target; the acked word never appears.
REQ-040 RESET_PC=32'hFFFF_FFFC -> second fetch at 32'h0; if_pc4 of the first instruction =0.
REQ-041 rst_n low for one cycle during DROP -> outputs at reset values; fetch restarts at RESET_PC; with IF_STALL_CNT_EN defined, stall_cnt=0.
